id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core, with load-use hazard detection.
- Captures decoded operands, register addresses and control from ID. Drives the RS1/RS2/RD addresses that EX-stage forwarding compares against EX/MEM and MEM/WB.
- Inserts bubbles on load-use hazards and on branch flush.
- Freezes on external memory stall.
- Keeps saturating counters of load-use stalls and flush bubbles for performance debug.

Parameters:
- DATA_W, 32, width of operand and immediate datapaths.
- CNT_W, 16, width of each performance counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- mem_stall_i  in  1  data-memory stall; holds the whole register.
- flush_i  in  1  branch taken in ID; the next captured entry is a bubble.
- ID_RS1addr_i  in  5  rs1 of the instruction in ID.
- ID_RS2addr_i  in  5  rs2 of the instruction in ID.
- ID_RDaddr_i  in  5  rd of the instruction in ID.
- ID_uses_rs1_i  in  1  the instruction in ID reads rs1.
- ID_uses_rs2_i  in  1  the instruction in ID reads rs2.
- ID_RS1data_i  in  DATA_W  register-file read data 1.
- ID_RS2data_i  in  DATA_W  register-file read data 2.
- ID_imm_i  in  DATA_W  sign-extended immediate.
- ID_funct_i  in  10  {funct7, funct3}.
- ID_ctrl_i  in  8  {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc, Branch}.
- ID_EX_RS1addr_o  out  5  registered rs1.
- ID_EX_RS2addr_o  out  5  registered rs2.
- ID_EX_RDaddr_o  out  5  registered rd.
- ID_EX_RS1data_o  out  DATA_W  registered operand 1.
- ID_EX_RS2data_o  out  DATA_W  registered operand 2.
- ID_EX_imm_o  out  DATA_W  registered immediate.
- ID_EX_funct_o  out  10  registered funct.
- ID_EX_ctrl_o  out  8  registered control; all-zero for a bubble.
- ID_EX_valid_o  out  1  1 = real instruction, 0 = bubble.
- hazard_stall_o  out  1  load-use hazard; PC and IF/ID must hold.
- stall_cnt_o  out  CNT_W  load-use stall cycles, saturating.
- bubble_cnt_o  out  CNT_W  flush bubbles inserted, saturating.

Behaviour:
- Reset (rst_i=0, asynchronous): every registered output is 0, both counters are 0, and hazard_stall_o is 0.
- Hazard detection is combinational on the current register and ID inputs:
  - hazard_stall_o = ID_EX_valid_o & ctrl.MemRead & (ID_EX_RDaddr_o≠0) & ((ID_uses_rs1_i & ID_RS1addr_i==ID_EX_RDaddr_o) | (ID_uses_rs2_i & ID_RS2addr_i==ID_EX_RDaddr_o)).
  - hazard_stall_o is forced to 0 while mem_stall_i=1.
- Each rising edge applies exactly one action, in priority order:
  1. mem_stall_i=1: hold every register. No counter changes.
  2. flush_i=1: load a bubble (ctrl=0, valid=0; address and data fields zeroed). bubble_cnt +1. flush_i wins over a simultaneous hazard; stall_cnt is not incremented.
  3. hazard_stall_o=1: load a bubble. stall_cnt +1.
  4. Otherwise: load all ID inputs and set valid=1.
- Latency: ID inputs appear at the outputs one cycle after capture.
- A load-use stall lasts exactly 1 cycle. The following cycle the bubble has valid=0, so hazard_stall_o drops and the held ID instruction is captured.
- Counters saturate at all-ones; no wrap.
- Reset mid-stall clears everything immediately. The first edge after release loads the ID inputs normally, or a bubble if flush_i=1.
- Data fields of a bubble are 0, so the EX-stage forwarding never matches on rd (rd=0, RegWrite=0).

Test Plan:
- Reset, then release and feed an ADD (rd=5, RegWrite) → outputs 0 during reset; one edge after release ID_EX_RDaddr_o=5, valid=1, ctrl matches the input.
- Feed LW x5 then ADD x6,x5,x7 (uses rs1) → hazard_stall_o=1 for one cycle, bubble with ctrl=0 loaded, stall_cnt=1; next edge the ADD is captured with RS1addr=5.
- LW x0 followed by a use of x0 → hazard_stall_o=0, no bubble.
- LW x5 followed by an instruction with uses_rs2=0 and rs2 field=5 → no stall.
- Assert flush_i in the same cycle as a load-use hazard → bubble_cnt +1, stall_cnt unchanged, valid=0.
- Hold mem_stall_i for 3 cycles with changing ID inputs → outputs and counters frozen, hazard_stall_o=0. Then force the counters to all-ones and trigger a stall → counters stay at all-ones.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decoded instruction from ID and presents it to EX one cycle
// later. A bubble (all fields zero, valid=0) replaces the instruction on a
// branch flush or on a load-use hazard. The whole register freezes while
// data memory stalls. Two saturating counters record load-use stalls and
// flush bubbles for performance debug.
//
// Handshake: there is no valid/ready pair here. mem_stall_i acts as a global
// "not ready" from downstream and holds every register. hazard_stall_o is the
// upstream "not ready" that tells PC and IF/ID to hold their contents.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  input  logic [4:0]        ID_RS1addr_i,
  input  logic [4:0]        ID_RS2addr_i,
  input  logic [4:0]        ID_RDaddr_i,
  input  logic              ID_uses_rs1_i,
  input  logic              ID_uses_rs2_i,
  input  logic [DATA_W-1:0] ID_RS1data_i,
  input  logic [DATA_W-1:0] ID_RS2data_i,
  input  logic [DATA_W-1:0] ID_imm_i,
  input  logic [9:0]        ID_funct_i,
  input  logic [7:0]        ID_ctrl_i,
  output logic [4:0]        ID_EX_RS1addr_o,
  output logic [4:0]        ID_EX_RS2addr_o,
  output logic [4:0]        ID_EX_RDaddr_o,
  output logic [DATA_W-1:0] ID_EX_RS1data_o,
  output logic [DATA_W-1:0] ID_EX_RS2data_o,
  output logic [DATA_W-1:0] ID_EX_imm_o,
  output logic [9:0]        ID_EX_funct_o,
  output logic [7:0]        ID_EX_ctrl_o,
  output logic              ID_EX_valid_o,
  output logic              hazard_stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Control layout: {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc, Branch}
  localparam int MEM_READ_BIT = 5;

  logic ex_is_load;
  logic rs1_conflict;
  logic rs2_conflict;
  logic load_bubble;

  // A load in EX whose rd is needed by the instruction in ID cannot be
  // forwarded in time. x0 never counts as a dependency.
  assign ex_is_load   = ID_EX_valid_o & ID_EX_ctrl_o[MEM_READ_BIT] & (ID_EX_RDaddr_o != 5'd0);
  assign rs1_conflict = ID_uses_rs1_i & (ID_RS1addr_i == ID_EX_RDaddr_o);
  assign rs2_conflict = ID_uses_rs2_i & (ID_RS2addr_i == ID_EX_RDaddr_o);
  assign hazard_stall_o = ~mem_stall_i & ex_is_load & (rs1_conflict | rs2_conflict);

  // Flush and hazard both produce a bubble; mem stall overrides either.
  assign load_bubble = flush_i | hazard_stall_o;

  // Pipeline register: hold on mem stall, bubble on flush/hazard, else capture ID.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ID_EX_RS1addr_o <= '0;
      ID_EX_RS2addr_o <= '0;
      ID_EX_RDaddr_o  <= '0;
      ID_EX_RS1data_o <= '0;
      ID_EX_RS2data_o <= '0;
      ID_EX_imm_o     <= '0;
      ID_EX_funct_o   <= '0;
      ID_EX_ctrl_o    <= '0;
      ID_EX_valid_o   <= 1'b0;
    end else if (!mem_stall_i) begin
      if (load_bubble) begin
        ID_EX_RS1addr_o <= '0;
        ID_EX_RS2addr_o <= '0;
        ID_EX_RDaddr_o  <= '0;
        ID_EX_RS1data_o <= '0;
        ID_EX_RS2data_o <= '0;
        ID_EX_imm_o     <= '0;
        ID_EX_funct_o   <= '0;
        ID_EX_ctrl_o    <= '0;
        ID_EX_valid_o   <= 1'b0;
      end else begin
        ID_EX_RS1addr_o <= ID_RS1addr_i;
        ID_EX_RS2addr_o <= ID_RS2addr_i;
        ID_EX_RDaddr_o  <= ID_RDaddr_i;
        ID_EX_RS1data_o <= ID_RS1data_i;
        ID_EX_RS2data_o <= ID_RS2data_i;
        ID_EX_imm_o     <= ID_imm_i;
        ID_EX_funct_o   <= ID_funct_i;
        ID_EX_ctrl_o    <= ID_ctrl_i;
        ID_EX_valid_o   <= 1'b1;
      end
    end
  end

  // Saturating performance counters; a flush takes credit over a coincident hazard.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else if (!mem_stall_i) begin
      if (flush_i) begin
        if (bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      end else if (hazard_stall_o) begin
        if (stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
